ps2_scan_rx: RTL

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_clk_filter.sv | 56 +++++
 rtl/ps2_scan_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and code constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [6:0] BLANK_CODE = 7'h7F;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the PS/2 lines, debounces ps2_clk and strobes on each accepted
// falling edge of the keyboard clock.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_dat,
    output logic o_fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_clk_meta;
    logic          r_clk_sync;
    logic          r_dat_meta;
    logic          r_dat_sync;
    logic          r_clk_filt;
    logic [CW-1:0] r_cnt;
    logic          r_fall;

    // Everything resets to the idle bus level so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_clk_filt <= 1'b1;
            r_cnt      <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= i_ps2_dat;
            r_dat_sync <= r_dat_meta;
            r_fall     <= 1'b0;
            if (r_clk_sync == r_clk_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_clk_filt <= r_clk_sync;
                r_cnt      <= '0;
                r_fall     <= ~r_clk_sync;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_dat  = r_dat_sync;
    assign o_fall = r_fall;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames bytes off the wire and tracks the currently
// held make code for a seven-segment letter display.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [6:0] sevbits,
    output logic       code_valid,
    output logic       frame_err,
    output logic       key_held
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    // frame_err lands exactly TIMEOUT_CYC cycles after the last fall strobe.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 2);

    logic w_fall;
    logic w_dat;
    logic w_frame_ok;
    logic w_timeout;

    ps2_state_t  r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic [TW-1:0] r_to_cnt;
    logic        r_brk;
    logic        r_ext;
    logic [6:0]  r_sevbits;
    logic        r_code_valid;
    logic        r_frame_err;
    logic        r_key_held;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_ps2_clk(ps2_clk),
        .i_ps2_dat(ps2_dat),
        .o_dat    (w_dat),
        .o_fall   (w_fall)
    );

    // In STOP, w_dat is the stop bit; parity must be odd over data plus parity.
    assign w_frame_ok = w_dat & (^{r_shift, r_parity});
    assign w_timeout  = (r_state != IDLE) && !w_fall && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
            r_sevbits    <= BLANK_CODE;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_key_held   <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            if ((r_state == IDLE) || w_fall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end

            if (w_timeout) begin
                r_state     <= IDLE;
                r_frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        if (!w_dat) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {w_dat, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_parity <= w_dat;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (!w_frame_ok) begin
                            r_frame_err <= 1'b1;
                            r_brk       <= 1'b0;
                            r_ext       <= 1'b0;
                        end else if (r_shift == BREAK_CODE) begin
                            r_brk <= 1'b1;
                        end else if (r_shift == EXT_CODE) begin
                            r_ext <= 1'b1;
                        end else if (!r_shift[7]) begin
                            // Extended keys are swallowed; break only blanks the matching held key.
                            if (r_ext) begin
                                r_ext <= 1'b0;
                                r_brk <= 1'b0;
                            end else if (r_brk) begin
                                r_brk <= 1'b0;
                                if (r_key_held && (r_shift[6:0] == r_sevbits)) begin
                                    r_sevbits  <= BLANK_CODE;
                                    r_key_held <= 1'b0;
                                end
                            end else begin
                                r_sevbits    <= r_shift[6:0];
                                r_key_held   <= 1'b1;
                                r_code_valid <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign sevbits    = r_sevbits;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;
    assign key_held   = r_key_held;

endmodule
